// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier control slice.
package mult_pkg;

    // Controller states, one per phase of the add/shift sequence.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Default operand width: one add/shift iteration per multiplier bit.
    localparam int ITER_DEF = 8;

    // Adder/subtractor function select, shared with the 9-bit adder.
    localparam logic FN_ADD = 1'b0;
    localparam logic FN_SUB = 1'b1;

endpackage

// File: rtl/mult_ctrl_if.sv
// Command/status bundle between the multiplier controller, the board
// switches and the X/A/B register unit.
//
// Handshake: there is no valid/ready pair here. Run and ClearA_LoadB are
// synchronised levels sampled every clock; the command outputs are
// single-cycle strobes that the register unit acts on at the next edge.
interface mult_ctrl_if;
    logic Run;           // start request (level, rising edge starts)
    logic ClearA_LoadB;  // IDLE-only: clear X/A, load B from switches
    logic M;             // current multiplier LSB, B[0]
    logic Ld_B;          // load B from switches
    logic Clr_XA;        // clear X and A
    logic Ld_XA;         // load X/A from adder result
    logic Fn;            // adder function, meaningful with Ld_XA
    logic Shift_En;      // arithmetic right shift of X:A:B
    logic Busy;          // sequence in progress
    logic Done;          // product stable, waiting for Run to drop

    // Environment side: switches and register unit.
    modport master (
        output Run, ClearA_LoadB, M,
        input  Ld_B, Clr_XA, Ld_XA, Fn, Shift_En, Busy, Done
    );

    // Controller side.
    modport slave (
        input  Run, ClearA_LoadB, M,
        output Ld_B, Clr_XA, Ld_XA, Fn, Shift_En, Busy, Done
    );
endinterface

// File: rtl/mult_ctrl_run_edge.sv
// Registered copy of Run plus rising-edge detect. The register resets to 1
// so a Run level held through reset is not mistaken for a fresh start.
module run_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic run_i,
    output logic start_o
);

    logic run_q;

    // Track the previous Run level; reset high to swallow a held Run.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_q <= 1'b1;
        end else begin
            run_q <= run_i;
        end
    end

    assign start_o = run_i & ~run_q;

endmodule

// File: rtl/mult_ctrl.sv
// Control FSM for the 8-bit signed shift-add multiplier. One ADD/SHIFT pair
// per multiplier bit; the last ADD subtracts so the result is two's
// complement. Command strobes are registered per state, except Ld_XA/Fn
// (follow M in ADD) and the IDLE switch load (follows ClearA_LoadB).
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = $clog2(ITER)
) (
    input  logic             Clk,
    input  logic             Reset,
    mult_ctrl_if.slave       bus,
    output state_t           dbg_state_o,
    output logic [CNT_W-1:0] dbg_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Registered per-state strobes.
    logic clr_q;
    logic add_q;
    logic fn_q;
    logic shift_q;
    logic busy_q;
    logic done_q;

    logic start;
    logic sw_load;

    run_edge u_run_edge (
        .Clk     (Clk),
        .Reset   (Reset),
        .run_i   (bus.Run),
        .start_o (start)
    );

    assign cnt_d = cnt_q + CNT_W'(1);

    // Sequence CLR -> (ADD, SHIFT) x ITER -> HOLD and register the strobes
    // that belong to the state being entered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            add_q   <= 1'b0;
            fn_q    <= FN_ADD;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                CLR: begin
                    state_q <= ADD;
                    cnt_q   <= '0;
                    clr_q   <= 1'b0;
                    add_q   <= 1'b1;
                    fn_q    <= (CNT_LAST == '0) ? FN_SUB : FN_ADD;
                end
                ADD: begin
                    state_q <= SHIFT;
                    add_q   <= 1'b0;
                    fn_q    <= FN_ADD;
                    shift_q <= 1'b1;
                end
                SHIFT: begin
                    shift_q <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        // Counter parks at its last value; CLR restarts it.
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ADD;
                        cnt_q   <= cnt_d;
                        add_q   <= 1'b1;
                        fn_q    <= (cnt_d == CNT_LAST) ? FN_SUB : FN_ADD;
                    end
                end
                HOLD: begin
                    if (!bus.Run) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    clr_q   <= 1'b0;
                    add_q   <= 1'b0;
                    fn_q    <= FN_ADD;
                    shift_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Switch load only in IDLE and only when no start is being taken.
    assign sw_load = (state_q == IDLE) & bus.ClearA_LoadB & ~start;

    assign bus.Ld_B     = sw_load;
    assign bus.Clr_XA   = clr_q | sw_load;
    assign bus.Ld_XA    = add_q & bus.M;
    assign bus.Fn       = add_q & bus.M & fn_q;
    assign bus.Shift_En = shift_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a cycle-level reference model derived from the
// documented timeline, a small X/A/B register-unit model that turns the
// command strobes into a real product, and directed multiplies with
// hand-computed results.
module tb_mult_ctrl;
    import mult_pkg::*;

    localparam int ITER   = ITER_DEF;
    localparam int CNT_W  = $clog2(ITER);
    localparam int T_HOLD = 2 * ITER + 2;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    state_t dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    mult_ctrl_if bus ();

    mult_ctrl #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_cnt_o   (dbg_cnt)
    );

    // Clock.
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register-unit model: switches, X, A, B.
    logic [7:0] sw = 8'h00;
    logic [7:0] a_r = 8'h00;
    logic [7:0] b_r = 8'h00;
    logic       x_r = 1'b0;
    logic s_ldb, s_clr, s_ldxa, s_fn, s_sh;
    logic [8:0] op9, sum9;

    assign bus.M = b_r[0];
    assign op9   = {sw[7], sw};
    assign sum9  = {a_r[7], a_r} + (s_fn ? (~op9 + 9'd1) : op9);

    always @(posedge Clk) begin
        if (s_ldb) b_r <= sw;
        if (s_clr) begin
            x_r <= 1'b0;
            a_r <= 8'h00;
        end
        if (s_ldxa) {x_r, a_r} <= sum9;
        if (s_sh) begin
            a_r <= {x_r, a_r[7:1]};
            b_r <= {a_r[0], b_r[7:1]};
        end
    end

    // Reference model: cycles since the start edge (-1 when idle).
    int   m_phase = -1;
    logic m_runq  = 1'b1;
    logic chk_en  = 1'b0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_phase <= -1;
            m_runq  <= 1'b1;
            chk_en  <= 1'b1;
        end else begin
            m_runq <= bus.Run;
            if (m_phase < 0) begin
                if (bus.Run && !m_runq) m_phase <= 1;
            end else if (m_phase < T_HOLD) begin
                m_phase <= m_phase + 1;
            end else if (!bus.Run) begin
                m_phase <= -1;
            end
        end
    end

    // Compare process: outputs against the model on every cycle.
    logic e_idle, e_clr, e_add, e_sh, e_hold, e_start, e_ldb, e_ldxa;
    int   e_k;
    state_t e_state;

    always @(negedge Clk) begin
        s_ldb  <= bus.Ld_B;
        s_clr  <= bus.Clr_XA;
        s_ldxa <= bus.Ld_XA;
        s_fn   <= bus.Fn;
        s_sh   <= bus.Shift_En;
        if (chk_en) begin
            e_idle  = (m_phase < 0);
            e_clr   = (m_phase == 1);
            e_add   = (m_phase >= 2) && (m_phase < T_HOLD) && (m_phase % 2 == 0);
            e_sh    = (m_phase >= 2) && (m_phase < T_HOLD) && (m_phase % 2 == 1);
            e_hold  = (m_phase == T_HOLD);
            e_k     = (m_phase - 2) / 2;
            e_start = e_idle && bus.Run && !m_runq;
            e_ldb   = e_idle && bus.ClearA_LoadB && !e_start;
            e_ldxa  = e_add && bus.M;
            e_state = e_idle ? IDLE : e_clr ? CLR : e_add ? ADD : e_sh ? SHIFT : HOLD;
            check("state", 32'(dbg_state), 32'(e_state));
            check("Ld_B", 32'(bus.Ld_B), 32'(e_ldb));
            check("Clr_XA", 32'(bus.Clr_XA), 32'(e_clr || e_ldb));
            check("Ld_XA", 32'(bus.Ld_XA), 32'(e_ldxa));
            check("Fn", 32'(bus.Fn), 32'(e_ldxa && (e_k == ITER - 1)));
            check("Shift_En", 32'(bus.Shift_En), 32'(e_sh));
            check("Busy", 32'(bus.Busy), 32'(e_clr || e_add || e_sh));
            check("Done", 32'(bus.Done), 32'(e_hold));
            if (e_add || e_sh) check("cnt", 32'(dbg_cnt), 32'(e_k));
        end
    end

    // Driver tasks.
    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] b);
        sw = b;
        bus.ClearA_LoadB = 1'b1;
        cyc(1);
        bus.ClearA_LoadB = 1'b0;
    endtask

    // Start a multiply with Run low beforehand; B already holds b.
    task automatic do_mult(input string tag, input logic [7:0] s, input logic [7:0] b,
                           input int exp_ld, input int exp_fn, input logic [15:0] exp_prod);
        int n, ld, fn, sh, hold_bad;
        logic signed [15:0] arith;
        state_t first_state;
        n = 0; ld = 0; fn = 0; sh = 0; hold_bad = 0;
        first_state = IDLE;
        sw = s;
        bus.Run = 1'b1;
        while (!bus.Done && n < 40) begin
            cyc(1);
            n++;
            if (n == 1) first_state = dbg_state;
            ld += int'(bus.Ld_XA);
            fn += int'(bus.Fn);
            sh += int'(bus.Shift_En);
        end
        arith = $signed({{8{s[7]}}, s}) * $signed({{8{b[7]}}, b});
        check({tag, ".clr_first"}, 32'(first_state), 32'(CLR));
        check({tag, ".latency"}, n, T_HOLD);
        check({tag, ".ld_xa_cnt"}, ld, exp_ld);
        check({tag, ".fn_cnt"}, fn, exp_fn);
        check({tag, ".shift_cnt"}, sh, ITER);
        check({tag, ".prod_lit"}, {16'h0, a_r, b_r}, {16'h0, exp_prod});
        check({tag, ".prod_arith"}, {16'h0, a_r, b_r}, {16'h0, arith});
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (!bus.Done || bus.Shift_En || bus.Ld_XA) hold_bad++;
        end
        check({tag, ".hold_stable"}, hold_bad, 0);
        check({tag, ".hold_prod"}, {16'h0, a_r, b_r}, {16'h0, exp_prod});
        bus.Run = 1'b0;
        cyc(1);
        check({tag, ".idle_done"}, 32'(bus.Done), 0);
        check({tag, ".idle_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int nb;
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b0;

        // Reset with Run held high; no start afterwards.
        cyc(3);
        Reset = 1'b0;
        cyc(1);
        check("rst.state", 32'(dbg_state), 32'(IDLE));
        check("rst.cnt", 32'(dbg_cnt), 0);
        check("rst.busy", 32'(bus.Busy), 0);
        check("rst.done", 32'(bus.Done), 0);
        cyc(5);
        check("held_run.state", 32'(dbg_state), 32'(IDLE));
        bus.Run = 1'b0;
        cyc(1);

        // 5 * 7 = 35: adds in the first three iterations only.
        load_b(8'h07);
        do_mult("b07", 8'h05, 8'h07, 3, 0, 16'h0023);

        // ClearA_LoadB held three cycles in IDLE.
        sw = 8'h5A;
        bus.ClearA_LoadB = 1'b1;
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.Ld_B && bus.Clr_XA) nb++;
            cyc(1);
        end
        bus.ClearA_LoadB = 1'b0;
        #1;
        check("clb.ldb_off", 32'(bus.Ld_B), 0);
        check("clb.count", nb, 3);
        check("clb.b_loaded", 32'(b_r), 32'h5A);

        // Start and ClearA_LoadB together: start wins, B kept; switch
        // stays held through the multiply and must be ignored.
        bus.ClearA_LoadB = 1'b1;
        sw = 8'h02;
        bus.Run = 1'b1;
        #1;
        check("sim.ldb", 32'(bus.Ld_B), 0);
        check("sim.clr", 32'(bus.Clr_XA), 0);
        do_mult("sim", 8'h02, 8'h5A, 4, 0, 16'h00B4);
        bus.ClearA_LoadB = 1'b0;

        // 3 * -1 = -3: every iteration adds, the last subtracts.
        load_b(8'hFF);
        do_mult("bff", 8'h03, 8'hFF, 8, 1, 16'hFFFD);

        // -128 * -128 = 16384.
        load_b(8'h80);
        do_mult("b80", 8'h80, 8'h80, 1, 1, 16'h4000);

        // 127 * -127 = -16129.
        load_b(8'h81);
        do_mult("b81", 8'h7F, 8'h81, 2, 1, 16'hC0FF);

        // Reset in SHIFT_4, then a full new multiply.
        load_b(8'hFF);
        sw = 8'h03;
        bus.Run = 1'b1;
        cyc(3 + 2 * 4);
        check("mid.state", 32'(dbg_state), 32'(SHIFT));
        check("mid.cnt", 32'(dbg_cnt), 4);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        check("mid_rst.state", 32'(dbg_state), 32'(IDLE));
        check("mid_rst.cnt", 32'(dbg_cnt), 0);
        check("mid_rst.busy", 32'(bus.Busy), 0);
        check("mid_rst.shift", 32'(bus.Shift_En), 0);
        bus.Run = 1'b0;
        cyc(1);
        load_b(8'hFF);
        do_mult("after_rst", 8'h03, 8'hFF, 8, 1, 16'hFFFD);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Control FSM that sequences the 8-bit shift-add multiplier datapath: the X/A/B register unit plus the 9-bit adder/subtractor.
- Issues B-load, XA-clear, conditional add or subtract, and arithmetic-shift commands, one iteration per multiplier bit.
- Final iteration subtracts for two's-complement signed multiply.
- Sits between the board-level Run/ClearA_LoadB switches (already synchronised) and the register unit.

Parameters:
ITER, 8, number of multiplier bits / add-shift iterations (≥2)
CNT_W, $clog2(ITER), iteration counter width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Run  in  1  start request, level; start on rising edge
ClearA_LoadB  in  1  level; in IDLE clears X/A and loads B from switches
M  in  1  current multiplier LSB (B[0])
Ld_B  out  1  load B register from switch data
Clr_XA  out  1  clear X and A registers (drives register-unit clear)
Ld_XA  out  1  load X/A from adder result
Fn  out  1  adder function: 0 = add, 1 = subtract; valid when Ld_XA=1
Shift_En  out  1  arithmetic right shift of X:A:B by one
Busy  out  1  high from CLR through last SHIFT
Done  out  1  high in HOLD

Behaviour:
- Decided: reset Reset, synchronous, active-high; clock Clk.
- States: IDLE, CLR, ADD, SHIFT, HOLD. Counter cnt counts 0..ITER-1.
- Reset (any state, mid-operation included) → IDLE, cnt=0, run_q=1, all outputs 0 on the next edge.
- run_q=1 after reset, so a Run held high through reset does not start a multiply; a fresh 0→1 edge is required.
- run_q is a registered copy of Run. A start edge is Run=1 && run_q=0.
- IDLE:
  - start edge → CLR.
  - Otherwise, if ClearA_LoadB=1, assert Ld_B=1 and Clr_XA=1 that cycle (combinational, each cycle it is held).
  - Start edge and ClearA_LoadB in the same cycle: start wins, no Ld_B.
- CLR: Clr_XA=1 for one cycle, cnt←0 → ADD.
- ADD:
  - Ld_XA=M (Mealy on M).
  - Fn=1 if cnt==ITER-1, else 0.
  - Ld_XA=0 when M=0: no add.
  - → SHIFT.
- SHIFT:
  - Shift_En=1.
  - If cnt==ITER-1 → HOLD, else cnt←cnt+1 → ADD.
- HOLD: Done=1, Busy=0. Run=0 → IDLE. Run stays high → remain in HOLD; result stays stable.
- Latency: start edge sampled at cycle 0.
  - CLR at cycle 1.
  - ADD_k at cycle 2+2k, SHIFT_k at cycle 3+2k.
  - HOLD (Done=1) at cycle 2·ITER+2, i.e. cycle 18 for ITER=8.
- Busy=1 in CLR/ADD/SHIFT only. ClearA_LoadB is ignored while Busy or Done.
- Exclusivity: at most one of Ld_B, Ld_XA, Shift_En is high in any cycle. Clr_XA never coincides with Ld_XA or Shift_En.
- No wrap: cnt never exceeds ITER-1. The next multiply restarts at 0 via CLR.
- B is not cleared by CLR, so a repeated Run multiplies the same B. A/X are cleared on every start.

Decomposition:
- Package mult_pkg:
  - state enum type (IDLE, CLR, ADD, SHIFT, HOLD)
  - ITER default constant
  - FN_ADD/FN_SUB localparams, shared with the adder
- One natural sub-module, run_edge: run_q register plus rising-edge detect, reset value 1.
- FSM and counter stay in mult_ctrl.

Test Plan:
- Reset with Run=1 held → IDLE, all outputs 0. Run stays high 5 cycles → no CLR. Run 0→1 → CLR one cycle later.
- IDLE, ClearA_LoadB=1 for 3 cycles → Ld_B=Clr_XA=1 for exactly 3 cycles. Same with Run edge simultaneous → CLR, Ld_B=0.
- M driven as B=0x07 bits shifting (1,1,1,0,0,0,0,0) → Ld_XA high in ADD_0..ADD_2 only, Fn=0 throughout. Done at cycle 18.
- M=1 every iteration (B=0xFF) → Ld_XA in all 8 ADD states, Fn=1 only in ADD_7. Integrated with the datapath, A=0x03, B=0xFF gives X:A:B = 0xFFFD (−3).
- Reset asserted in SHIFT_4 → next cycle IDLE, cnt=0, Busy=0. New Run edge → full 8-iteration sequence from CLR.
- HOLD with Run held 10 cycles → Done stays 1, no Shift_En/Ld_XA. Run=0 → IDLE next cycle, Done=0.
